// File: rtl/draft_sum_tx.sv
// draft_sum_tx: latches a_in+b_in (mod 256) on an accepted start and shifts it
// out as a UART-style frame on tx (start bit, 8 data bits LSB first, stop bit).
// tx_oe drives the pin output enable and follows busy.
// Optional macro SUM_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module draft_sum_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] a_in,
  input  logic [DATA_W-1:0] b_in,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] sum_out,
  output logic              tx,
  output logic              tx_oe
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SUM_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [IDX_W-1:0]  idx_reg, idx_next;
  logic [IDX_W-1:0]  idx_inc;
  logic [DATA_W-1:0] shift_reg, shift_next;
  logic [DATA_W-1:0] sum_reg, sum_next;
  logic [DATA_W-1:0] sum_calc;
  logic              tx_reg, tx_next;
  logic              busy_reg, busy_next;
  logic              done_reg, done_next;
  logic              bit_end;

  // Carry out of the adder is deliberately dropped.
  assign sum_calc = a_in + b_in;
  assign idx_inc  = idx_reg + IDX_W'(1);
  assign bit_end  = (cnt_reg == CNT_LAST);

  // Next-state and next-output logic; every register holds unless a case updates it.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;
    sum_next   = sum_reg;
    tx_next    = tx_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        tx_next   = 1'b1;
        busy_next = 1'b0;
        if (start) begin
          state_next = S_START;
          shift_next = sum_calc;
          sum_next   = sum_calc;
          cnt_next   = '0;
          idx_next   = '0;
          busy_next  = 1'b1;
          tx_next    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_next = S_DATA;
          cnt_next   = '0;
          idx_next   = '0;
          tx_next    = shift_reg[0];
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          cnt_next = '0;
          if (idx_reg == IDX_LAST) begin
`ifdef SUM_TX_PARITY_EN
            state_next = S_PARITY;
            tx_next    = ^shift_reg;
`else
            state_next = S_STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            idx_next = idx_inc;
            tx_next  = shift_reg[idx_inc];
          end
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
`ifdef SUM_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_next = S_STOP;
          cnt_next   = '0;
          tx_next    = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          // The first IDLE cycle carries done; a start there is accepted at the next edge.
          state_next = S_IDLE;
          cnt_next   = '0;
          busy_next  = 1'b0;
          done_next  = 1'b1;
          tx_next    = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
        idx_next   = '0;
        busy_next  = 1'b0;
        tx_next    = 1'b1;
      end
    endcase
  end

  // State and output registers; reset abandons any frame and forces the line idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
      sum_reg   <= '0;
      tx_reg    <= 1'b1;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
      sum_reg   <= sum_next;
      tx_reg    <= tx_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign tx      = tx_reg;
  assign tx_oe   = busy_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign sum_out = sum_reg;

endmodule

// File: tb/tb_draft_sum_tx.sv
// tb_draft_sum_tx: drives draft_sum_tx with CLKS_PER_BIT=4 and checks the serial
// frame cycle by cycle against a frame model built from the sum bits.
module tb_draft_sum_tx;

  localparam int C = 4;
`ifdef SUM_TX_PARITY_EN
  localparam int FRAME = 11;
`else
  localparam int FRAME = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a_in = 8'h00;
  logic [7:0] b_in = 8'h00;
  logic       busy, done, tx, tx_oe;
  logic [7:0] sum_out;

  int checks = 0;
  int errors = 0;

  draft_sum_tx #(.CLKS_PER_BIT(C), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .start(start),
    .busy(busy), .done(done), .sum_out(sum_out), .tx(tx), .tx_oe(tx_oe)
  );

  always #5 clk = ~clk;

  // Frame bit i of a frame carrying sum s: start, data LSB first, [parity], stop.
  function automatic logic exp_bit(input logic [7:0] s, input int i);
    if (i == 0) return 1'b0;
    if (i <= 8) return s[i-1];
`ifdef SUM_TX_PARITY_EN
    if (i == 9) return ^s;
`endif
    return 1'b1;
  endfunction

  task automatic check_idle(input string name, input logic [7:0] exp_sum);
    checks++;
    if ({tx, tx_oe, busy, done} !== 4'b1000) begin
      errors++;
      $display("FAIL %s idle_outputs got tx/oe/busy/done=%b want 1000", name, {tx, tx_oe, busy, done});
    end
    checks++;
    if (sum_out !== exp_sum) begin
      errors++;
      $display("FAIL %s sum_out got %02h want %02h", name, sum_out, exp_sum);
    end
  endtask

  // Called at the negedge just after the accepting edge; walks the frame and the done cycle.
  task automatic run_frame(input string name, input logic [7:0] exp_sum, input bit hold,
                           input bit scramble, input int change_k,
                           input logic [7:0] na, input logic [7:0] nb);
    int bad;
    bad = 0;
    for (int k = 0; k < FRAME*C; k++) begin
      checks++;
      if (tx !== exp_bit(exp_sum, k/C)) begin
        errors++; bad++;
        $display("FAIL %s tx k=%0d got %b want %b", name, k, tx, exp_bit(exp_sum, k/C));
      end
      checks++;
      if ({busy, tx_oe, done} !== 3'b110) begin
        errors++; bad++;
        $display("FAIL %s busy/oe/done k=%0d got %b want 110", name, k, {busy, tx_oe, done});
      end
      checks++;
      if (sum_out !== exp_sum) begin
        errors++; bad++;
        $display("FAIL %s sum_out k=%0d got %02h want %02h", name, k, sum_out, exp_sum);
      end
      if (scramble) begin
        start = 1'($urandom_range(0, 1));
        a_in  = 8'($urandom);
        b_in  = 8'($urandom);
      end
      if (k == change_k) begin
        a_in = na;
        b_in = nb;
      end
      @(negedge clk);
    end
    checks++;
    if ({busy, tx_oe, done, tx} !== 4'b0011) begin
      errors++; bad++;
      $display("FAIL %s done_cycle got busy/oe/done/tx=%b want 0011", name, {busy, tx_oe, done, tx});
    end
    checks++;
    if (sum_out !== exp_sum) begin
      errors++; bad++;
      $display("FAIL %s done_sum got %02h want %02h", name, sum_out, exp_sum);
    end
    if (!hold) start = 1'b0;
    $display("frame %s sum=%02h bits=%0d errors_in_frame=%0d", name, exp_sum, FRAME, bad);
  endtask

  // From a negedge with the DUT idle: request a frame, return at the first frame cycle.
  task automatic kick(input logic [7:0] a, input logic [7:0] b, input bit hold);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    check_idle("reset_held", 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset_release", 8'h00);
  endtask

  task automatic test_basic;
    kick(8'h23, 8'h45, 1'b0);
    run_frame("basic_68", 8'h68, 1'b0, 1'b0, -1, 8'h00, 8'h00);
    @(negedge clk);
    check_idle("basic_after", 8'h68);
  endtask

  task automatic test_reset_idle;
    #1 rst = 1'b1;
    #1;
    check_idle("reset_async_idle", 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset_idle_release", 8'h00);
  endtask

  task automatic test_carry;
    kick(8'hF0, 8'h20, 1'b0);
    run_frame("carry_10", 8'h10, 1'b0, 1'b0, -1, 8'h00, 8'h00);
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    kick(8'h01, 8'h02, 1'b1);
    run_frame("b2b_first_03", 8'h03, 1'b1, 1'b0, 5*C, 8'h10, 8'h10);
    @(negedge clk);
    start = 1'b0;
    run_frame("b2b_second_20", 8'h20, 1'b0, 1'b0, -1, 8'h00, 8'h00);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    logic [7:0] s;
    s = 8'h5A + 8'h11;
    kick(8'h5A, 8'h11, 1'b0);
    repeat (4*C + 1) @(negedge clk);
    checks++;
    if (tx !== s[3]) begin
      errors++;
      $display("FAIL reset_mid bit3 got %b want %b", tx, s[3]);
    end
    #1 rst = 1'b1;
    #1;
    check_idle("reset_mid_async", 8'h00);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle("reset_mid_release", 8'h00);
    kick(8'h30, 8'h0C, 1'b0);
    run_frame("after_reset_3c", 8'h3C, 1'b0, 1'b0, -1, 8'h00, 8'h00);
    @(negedge clk);
  endtask

  task automatic test_random;
    logic [7:0] a, b, s;
    for (int i = 0; i < 6; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      s = a + b;
      kick(a, b, 1'b0);
      run_frame($sformatf("random_%0d", i), s, 1'b0, 1'b1, -1, 8'h00, 8'h00);
      @(negedge clk);
      check_idle($sformatf("random_%0d_idle", i), s);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_reset_idle;
    test_carry;
    test_back_to_back;
    test_reset_mid_frame;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/draft_sum_tx.md
Name: draft_sum_tx

Overview:
- Transmit-side companion to the pin-level adder top. Captures the 8-bit sum of two operand bytes and sends it out as a UART-style serial frame on a single bidirectional pin.
- Drives the uio output and output-enable paths; the top maps `tx`/`tx_oe` onto `uio_out[0]`/`uio_oe[0]`.
- Instantiated inside the top; operands come from the `ui_in`/`uio_in` pin groups.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per serial bit; legal range 2..256.
- DATA_W, 8, operand, sum and data-bit width; fixed at 8 for this block.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high; clk and rst are the only clock and reset.
- a_in  input  8  operand A, sampled only on accepted start.
- b_in  input  8  operand B, sampled only on accepted start.
- start  input  1  request to transmit a_in+b_in; level-sampled each cycle.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse when a frame completes.
- sum_out  output  8  last latched sum, held until the next accepted start.
- tx  output  1  serial line, idle high.
- tx_oe  output  1  pin output enable; equals busy.

Behaviour:
- Reset (async assert, any time) values:
  - State = IDLE; tx=1, tx_oe=0, busy=0, done=0, sum_out=0.
  - Bit counter and cycle counter = 0.
  - A frame in progress is abandoned immediately; no partial stop bit is sent.
- Reset release: the first rising edge with rst low is an ordinary IDLE cycle.
- Arithmetic: sum = (a_in + b_in) mod 256; the carry is discarded (0xF0+0x20 -> 0x10).
- States: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1, busy=0.
  - If start=1 at edge N: latch sum into the shift register and sum_out, then enter START.
  - From edge N: busy=1, tx_oe=1, tx=0.
- START:
  - tx=0 for CLKS_PER_BIT cycles, then enter DATA with bit index 0.
- DATA:
  - tx = shift[index], LSB first; each bit is held CLKS_PER_BIT cycles.
  - After index 7, enter STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles, then return to IDLE.
  - On that edge: busy=0, tx_oe=0, and done=1 for exactly one cycle.
- Frame length: busy is high for exactly 10*CLKS_PER_BIT cycles.
- tx and tx_oe are registered outputs with no combinational path from any input.
- start while busy: ignored, not queued; operands and sum_out are unchanged.
- Back-to-back frames:
  - start=1 in the cycle done=1 (first IDLE cycle) is accepted.
  - This gives a contiguous frame with no extra idle bit.
- Operand changes after acceptance have no effect on the frame in flight.
- Cycle counter: counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary. Width is $clog2(CLKS_PER_BIT), minimum 1.

Optional Feature:
- Macro: SUM_TX_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = XOR of the 8 sum bits (even parity) for CLKS_PER_BIT cycles.
  - busy lasts 11*CLKS_PER_BIT cycles.
- When undefined:
  - No PARITY state and no parity logic; frame is 10 bits.

Test Plan:
1. CLKS_PER_BIT=4, rst pulse mid-idle -> tx=1, tx_oe=0, busy=0, done=0, sum_out=0 immediately on assert, without waiting for a clock edge.
2. a_in=0x23, b_in=0x45, start for one cycle -> sum_out=0x68.
   - tx sequence 0,0,0,0,1,0,1,1,0,1, each bit 4 cycles.
   - busy high 40 cycles; done pulses once as busy falls.
3. a_in=0xF0, b_in=0x20 -> sum_out=0x10.
   - Data bits 0,0,0,0,1,0,0,0; carry is not transmitted.
4. start held high continuously with operands 0x01/0x02, changed to 0x10/0x10 mid-frame:
   - First frame sends 0x03.
   - Second frame starts the cycle done=1 and sends 0x20.
   - No idle gap between the frames.
5. rst asserted during DATA bit 3 -> tx=1 and tx_oe=0 at once.
   - After release, the next start sends a complete fresh frame.
6. SUM_TX_PARITY_EN defined, sum 0x68 -> parity bit 1 after data, then stop.
   - busy high 44 cycles.
   - With sum 0x03 the parity bit is 0.
